ps2_key_ctrl: RTL and testbench

Sequencer between the PS/2 byte receiver and the keyboard display datapath (scan-code ROM plus 7-seg digit drivers).
- Pops scan-code bytes from the receiver with a ready/next handshake.
- Parses make, break (F0) and extended (E0) prefixes and suppresses typematic repeats.
- Runs one scan-code-to-ASCII ROM lookup per new key press.
- Maintains a 2-digit BCD press counter and drives key/ASCII/count registers for display.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_key_ctrl_bcd_cnt2.sv | 40 ++++
 rtl/ps2_key_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key sequencer.
// Optional shift-key handling is enabled with the PS2_SHIFT_EN macro.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ROM_REQ,
        ROM_WAIT,
        UPDATE
    } state_e;

    typedef logic [3:0] bcd_t;

    function automatic logic is_shift(input logic [7:0] b);
        return (b == PS2_LSHIFT) || (b == PS2_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_key_ctrl_bcd_cnt2.sv
// Two-digit BCD counter with increment strobe; wraps 99 -> 00.
// Cleared only by the asynchronous reset.
module bcd_cnt2
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    output logic [7:0] cnt
);

    bcd_t units_q, units_d;
    bcd_t tens_q, tens_d;

    always_comb begin
        units_d = units_q;
        tens_d  = tens_q;
        if (inc) begin
            if (units_q == 4'd9) begin
                units_d = 4'd0;
                tens_d  = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            units_q <= 4'd0;
            tens_q  <= 4'd0;
        end else begin
            units_q <= units_d;
            tens_q  <= tens_d;
        end
    end

    assign cnt = {tens_q, units_q};

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: pops bytes, parses prefixes, looks up ASCII.
// Optional shift-key handling is enabled with the PS2_SHIFT_EN macro.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int ROM_LAT    = 1,
    parameter int CNT_DIGITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       ready,
    input  logic       overflow,
    output logic       nextdata_n,
    output logic [7:0] rom_addr,
    output logic       rom_rd_en,
    input  logic [7:0] rom_data,
    output logic [7:0] key_code,
    output logic [7:0] ascii,
    output logic [7:0] cnt_bcd,
    output logic       disp_en
);

    state_e     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic       held_q, held_d;
    logic [7:0] held_code_q, held_code_d;
    logic [7:0] key_q, key_d;
    logic [7:0] ascii_q, ascii_d;
    logic       disp_q, disp_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] rdata_q, rdata_d;
    logic [1:0] wait_q, wait_d;
    logic       cnt_inc;
    logic [7:0] ascii_new;
    logic [CNT_DIGITS*4-1:0] cnt_w;
`ifdef PS2_SHIFT_EN
    logic       shift_q, shift_d;
`endif

    always_comb begin
        ascii_new = rdata_q;
`ifdef PS2_SHIFT_EN
        // Upper-case only the lower-case letter range while shift is held
        if (shift_q && rdata_q >= 8'h61 && rdata_q <= 8'h7A)
            ascii_new = rdata_q - 8'h20;
`endif
        if (ext_q)
            ascii_new = 8'h00;
    end

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        held_d      = held_q;
        held_code_d = held_code_q;
        key_d       = key_q;
        ascii_d     = ascii_q;
        disp_d      = disp_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        wait_d      = wait_q;
        cnt_inc     = 1'b0;
`ifdef PS2_SHIFT_EN
        shift_d     = shift_q;
`endif
        case (state_q)
            IDLE: begin
                if (overflow) begin
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else if (ready) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                byte_d  = data;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = IDLE;
                if (byte_q == PS2_BREAK) begin
                    brk_d = 1'b1;
                end else if (byte_q == PS2_EXT) begin
                    ext_d = 1'b1;
                end else if (brk_q) begin
                    if (held_q && byte_q == held_code_q) begin
                        held_d = 1'b0;
                        disp_d = 1'b0;
                    end
`ifdef PS2_SHIFT_EN
                    if (is_shift(byte_q))
                        shift_d = 1'b0;
`endif
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else if (held_q && byte_q == held_code_q) begin
                    ext_d = 1'b0;
`ifdef PS2_SHIFT_EN
                end else if (is_shift(byte_q)) begin
                    shift_d = 1'b1;
                    ext_d   = 1'b0;
`endif
                end else if (ext_q) begin
                    state_d = UPDATE;
                end else begin
                    addr_d  = byte_q;
                    state_d = ROM_REQ;
                end
            end
            ROM_REQ: begin
                wait_d  = 2'd0;
                state_d = ROM_WAIT;
            end
            ROM_WAIT: begin
                if (wait_q == 2'(ROM_LAT - 1)) begin
                    rdata_d = rom_data;
                    state_d = UPDATE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            UPDATE: begin
                key_d       = byte_q;
                ascii_d     = ascii_new;
                held_code_d = byte_q;
                held_d      = 1'b1;
                disp_d      = 1'b1;
                cnt_inc     = 1'b1;
                ext_d       = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_q      <= 8'h00;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            held_q      <= 1'b0;
            held_code_q <= 8'h00;
            key_q       <= 8'h00;
            ascii_q     <= 8'h00;
            disp_q      <= 1'b0;
            addr_q      <= 8'h00;
            rdata_q     <= 8'h00;
            wait_q      <= 2'd0;
`ifdef PS2_SHIFT_EN
            shift_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            held_q      <= held_d;
            held_code_q <= held_code_d;
            key_q       <= key_d;
            ascii_q     <= ascii_d;
            disp_q      <= disp_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            wait_q      <= wait_d;
`ifdef PS2_SHIFT_EN
            shift_q     <= shift_d;
`endif
        end
    end

    bcd_cnt2 u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .cnt   (cnt_w)
    );

    assign nextdata_n = (state_q != FETCH);
    assign rom_rd_en  = (state_q == ROM_REQ);
    assign rom_addr   = addr_q;
    assign key_code   = key_q;
    assign ascii      = ascii_q;
    assign disp_en    = disp_q;
    assign cnt_bcd    = cnt_w[7:0];

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with a 1-cycle synchronous ROM model.
// Shift-key vectors run only when PS2_SHIFT_EN is defined.
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       nextdata_n;
    logic [7:0] rom_addr;
    logic       rom_rd_en;
    logic [7:0] rom_data = 8'h00;
    logic [7:0] key_code;
    logic [7:0] ascii;
    logic [7:0] cnt_bcd;
    logic       disp_en;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int roms   = 0;
    int sent   = 0;

    ps2_key_ctrl #(.ROM_LAT(1), .CNT_DIGITS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .nextdata_n (nextdata_n),
        .rom_addr   (rom_addr),
        .rom_rd_en  (rom_rd_en),
        .rom_data   (rom_data),
        .key_code   (key_code),
        .ascii      (ascii),
        .cnt_bcd    (cnt_bcd),
        .disp_en    (disp_en)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        case (a)
            8'h1C:   return 8'h61;
            8'h32:   return 8'h62;
            8'h2A:   return 8'h76;
            8'h75:   return 8'h38;
            default: return 8'h3F;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= rom_fn(rom_addr);
        if (rst_n && !nextdata_n) pops <= pops + 1;
        if (rst_n && rom_rd_en) roms <= roms + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit seen = 1'b0;
        data  = b;
        ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (!nextdata_n) seen = 1'b1;
        end
        if (!seen) chk("pop_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        ready = 1'b0;
        sent++;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        data     = 8'h00;
        ready    = 1'b0;
        overflow = 1'b0;
        #12;
        chk("rst_key",   32'(key_code),   32'h00);
        chk("rst_ascii", 32'(ascii),      32'h00);
        chk("rst_cnt",   32'(cnt_bcd),    32'h00);
        chk("rst_disp",  32'(disp_en),    32'd0);
        chk("rst_ndata", 32'(nextdata_n), 32'd1);
        chk("rst_rden",  32'(rom_rd_en),  32'd0);
        chk("rst_addr",  32'(rom_addr),   32'h00);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // first press, cycle-exact
        data  = 8'h1C;
        ready = 1'b1;
        @(posedge clk); #1;
        chk("fetch_pop", 32'(nextdata_n), 32'd0);
        @(posedge clk); #1;
        ready = 1'b0;
        sent++;
        chk("pop_one_cycle", 32'(nextdata_n), 32'd1);
        repeat (3) @(posedge clk);
        #1 chk("early_key", 32'(key_code), 32'h00);
        @(posedge clk); #1;
        chk("p1_key",   32'(key_code), 32'h1C);
        chk("p1_ascii", 32'(ascii),    32'h61);
        chk("p1_cnt",   32'(cnt_bcd),  32'h01);
        chk("p1_disp",  32'(disp_en),  32'd1);
        chk("p1_pops",  32'(pops),     32'd1);
        chk("p1_roms",  32'(roms),     32'd1);

        // typematic repeats
        repeat (3) send_byte(8'h1C);
        chk("rep_cnt",  32'(cnt_bcd), 32'h01);
        chk("rep_roms", 32'(roms),    32'd1);
        chk("rep_pops", 32'(pops),    32'd4);

        // new key replaces held key
        send_byte(8'h32);
        chk("p2_key",   32'(key_code), 32'h32);
        chk("p2_ascii", 32'(ascii),    32'h62);
        chk("p2_cnt",   32'(cnt_bcd),  32'h02);

        // release of a non-held key is ignored
        send_byte(8'hF0);
        send_byte(8'h2A);
        chk("rel_other_disp", 32'(disp_en),  32'd1);
        chk("rel_other_cnt",  32'(cnt_bcd),  32'h02);
        chk("rel_other_key",  32'(key_code), 32'h32);

        send_byte(8'hF0);
        send_byte(8'h32);
        chk("rel_disp",  32'(disp_en),  32'd0);
        chk("rel_key",   32'(key_code), 32'h32);
        chk("rel_ascii", 32'(ascii),    32'h62);
        chk("rel_cnt",   32'(cnt_bcd),  32'h02);

        // extended make skips the ROM
        send_byte(8'hE0);
        send_byte(8'h75);
        chk("ext_key",   32'(key_code), 32'h75);
        chk("ext_ascii", 32'(ascii),    32'h00);
        chk("ext_cnt",   32'(cnt_bcd),  32'h03);
        chk("ext_roms",  32'(roms),     32'd2);
        chk("ext_disp",  32'(disp_en),  32'd1);

        // E0 F0 ordering releases the extended key
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("ext_rel_disp", 32'(disp_en), 32'd0);
        chk("ext_rel_cnt",  32'(cnt_bcd), 32'h03);

        // overflow in IDLE discards the pending E0
        send_byte(8'hE0);
        overflow = 1'b1;
        repeat (3) @(posedge clk);
        #1 overflow = 1'b0;
        send_byte(8'h75);
        chk("ovf_ascii", 32'(ascii),   32'h38);
        chk("ovf_roms",  32'(roms),    32'd3);
        chk("ovf_cnt",   32'(cnt_bcd), 32'h04);
        chk("pops_total", 32'(pops),   32'(sent));

        // reset while the ROM lookup is in flight
        begin
            bit seen = 1'b0;
            data  = 8'h1C;
            ready = 1'b1;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(posedge clk); #1;
                ready = nextdata_n ? ready : 1'b0;
                if (rom_rd_en) seen = 1'b1;
            end
            if (!seen) chk("rdreq_timeout", 32'd0, 32'd1);
            ready = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            chk("midrst_key",   32'(key_code),   32'h00);
            chk("midrst_ascii", 32'(ascii),      32'h00);
            chk("midrst_cnt",   32'(cnt_bcd),    32'h00);
            chk("midrst_disp",  32'(disp_en),    32'd0);
            chk("midrst_ndata", 32'(nextdata_n), 32'd1);
            chk("midrst_rden",  32'(rom_rd_en),  32'd0);
            chk("midrst_addr",  32'(rom_addr),   32'h00);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #1 chk("midrst_after", 32'(key_code), 32'h00);
        end

        // BCD count through 99 and wrap
        for (int i = 1; i <= 100; i++) begin
            logic [7:0] exp;
            exp = {4'((i % 100) / 10), 4'(i % 10)};
            send_byte((i % 2 == 1) ? 8'h1C : 8'h32);
            chk("bcd_cnt", 32'(cnt_bcd), 32'(exp));
        end

`ifdef PS2_SHIFT_EN
        do_reset();
        send_byte(8'h12);
        chk("sh_make_cnt", 32'(cnt_bcd), 32'h00);
        send_byte(8'h1C);
        chk("sh_ascii", 32'(ascii),   32'h41);
        chk("sh_cnt",   32'(cnt_bcd), 32'h01);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h12);
        send_byte(8'h1C);
        chk("unsh_ascii", 32'(ascii),   32'h61);
        chk("unsh_cnt",   32'(cnt_bcd), 32'h02);
`else
        do_reset();
        send_byte(8'h12);
        chk("plain12_key", 32'(key_code), 32'h12);
        chk("plain12_cnt", 32'(cnt_bcd),  32'h01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
